// File: rtl/c_decompress_stage.sv
`timescale 1ns/1ps
// c_decompress_stage: expands RV32C 16-bit instructions into RV32I equivalents and
// registers the result for decode. Supports stall hold and branch-redirect flush.
module c_decompress_stage #(
   parameter int unsigned XLEN        = 32,
   parameter bit          ILLEGAL_NOP = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_in,
   input  logic [31:0]     inst_in,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            sel_for_branch,
   input  logic            stall,
   output logic [XLEN-1:0] pc_out,
   output logic [31:0]     inst_out,
   output logic            is_compressed_o,
   output logic            illegal_o,
   output logic            out_valid
);

   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_REG    = 7'b0110011;
   localparam logic [6:0]  OP_LUI    = 7'b0110111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;
   localparam logic [31:0] EBREAK    = 32'h0010_0073;
   localparam logic [4:0]  X0 = 5'd0;
   localparam logic [4:0]  X1 = 5'd1;
   localparam logic [4:0]  X2 = 5'd2;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3);
      return {imm[12], imm[10:5], X0, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OP_REG};
   endfunction

   logic [15:0] c;
   logic [4:0]  rd_full, rs2_full, rdp, rs2p;
   logic [11:0] imm6, imm_lw, imm_4spn, imm_16sp, imm_lwsp, imm_swsp;
   logic [19:0] imm_lui;
   logic [20:0] imm_j;
   logic [12:0] imm_b;

   assign c        = inst_in[15:0];
   assign rd_full  = c[11:7];
   assign rs2_full = c[6:2];
   assign rdp      = {2'b01, c[9:7]};
   assign rs2p     = {2'b01, c[4:2]};
   assign imm6     = {{6{c[12]}}, c[12], c[6:2]};
   assign imm_lw   = {5'b0, c[5], c[12:10], c[6], 2'b00};
   assign imm_4spn = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00};
   assign imm_16sp = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
   assign imm_lwsp = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
   assign imm_swsp = {4'b0, c[8:7], c[12:9], 2'b00};
   assign imm_lui  = {{14{c[12]}}, c[12], c[6:2]};
   assign imm_j    = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
   assign imm_b    = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};

   logic [31:0] exp_inst;
   logic        exp_comp, exp_illegal;

   always_comb begin
      // NOTE: every variable written here is defaulted first, so no path can infer a latch.
      exp_inst    = {16'h0000, c};
      exp_comp    = 1'b1;
      exp_illegal = 1'b0;
      if (c[1:0] == 2'b11) begin
         exp_inst = inst_in;
         exp_comp = 1'b0;
      end else begin
         case ({c[1:0], c[15:13]})
            5'b00_000: begin
               exp_illegal = (c[12:5] == 8'h00);
               exp_inst    = enc_i(imm_4spn, X2, 3'b000, rs2p, OP_IMM);
            end
            5'b00_010: exp_inst = enc_i(imm_lw, rdp, 3'b010, rs2p, OP_LOAD);
            5'b00_110: exp_inst = enc_s(imm_lw, rs2p, rdp);
            5'b01_000: exp_inst = enc_i(imm6, rd_full, 3'b000, rd_full, OP_IMM);
            5'b01_001: exp_inst = enc_j(imm_j, X1);
            5'b01_010: exp_inst = enc_i(imm6, X0, 3'b000, rd_full, OP_IMM);
            5'b01_011: begin
               exp_illegal = ({c[12], c[6:2]} == 6'd0);
               if (rd_full == X2) exp_inst = enc_i(imm_16sp, X2, 3'b000, X2, OP_IMM);
               else               exp_inst = {imm_lui, rd_full, OP_LUI};
            end
            5'b01_100: begin
               case (c[11:10])
                  2'b00: begin
                     exp_illegal = c[12];
                     exp_inst    = enc_i({7'b0000000, c[6:2]}, rdp, 3'b101, rdp, OP_IMM);
                  end
                  2'b01: begin
                     exp_illegal = c[12];
                     exp_inst    = enc_i({7'b0100000, c[6:2]}, rdp, 3'b101, rdp, OP_IMM);
                  end
                  2'b10: exp_inst = enc_i(imm6, rdp, 3'b111, rdp, OP_IMM);
                  default: begin
                     // c[12]=1 selects the RV64-only SUBW/ADDW group and reserved slots.
                     exp_illegal = c[12];
                     case (c[6:5])
                        2'b00:   exp_inst = enc_r(7'b0100000, rs2p, rdp, 3'b000, rdp);
                        2'b01:   exp_inst = enc_r(7'b0000000, rs2p, rdp, 3'b100, rdp);
                        2'b10:   exp_inst = enc_r(7'b0000000, rs2p, rdp, 3'b110, rdp);
                        default: exp_inst = enc_r(7'b0000000, rs2p, rdp, 3'b111, rdp);
                     endcase
                  end
               endcase
            end
            5'b01_101: exp_inst = enc_j(imm_j, X0);
            5'b01_110: exp_inst = enc_b(imm_b, rdp, 3'b000);
            5'b01_111: exp_inst = enc_b(imm_b, rdp, 3'b001);
            5'b10_000: begin
               exp_illegal = c[12];
               exp_inst    = enc_i({7'b0000000, c[6:2]}, rd_full, 3'b001, rd_full, OP_IMM);
            end
            5'b10_010: begin
               exp_illegal = (rd_full == X0);
               exp_inst    = enc_i(imm_lwsp, X2, 3'b010, rd_full, OP_LOAD);
            end
            5'b10_100: begin
               if (!c[12]) begin
                  if (rs2_full == X0) begin
                     exp_illegal = (rd_full == X0);
                     exp_inst    = enc_i(12'd0, rd_full, 3'b000, X0, OP_JALR);
                  end else begin
                     exp_inst = enc_r(7'b0000000, rs2_full, X0, 3'b000, rd_full);
                  end
               end else if (rs2_full == X0) begin
                  if (rd_full == X0) exp_inst = EBREAK;
                  else               exp_inst = enc_i(12'd0, rd_full, 3'b000, X1, OP_JALR);
               end else begin
                  exp_inst = enc_r(7'b0000000, rs2_full, rd_full, 3'b000, rd_full);
               end
            end
            5'b10_110: exp_inst = enc_s(imm_swsp, rs2_full, X2);
            default:   exp_illegal = 1'b1;
         endcase
         if (exp_illegal) exp_inst = ILLEGAL_NOP ? NOP_INST : {16'h0000, c};
      end
   end

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     inst_q, inst_d;
   logic            comp_q, comp_d;
   logic            ill_q, ill_d;
   logic            load;

   assign in_ready = ~valid_q | ~stall;
   assign load     = in_valid & in_ready & ~sel_for_branch;

   always_comb begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      comp_d  = comp_q;
      ill_d   = ill_q;
      valid_d = valid_q & stall;
      if (load) begin
         pc_d    = pc_in;
         inst_d  = exp_inst;
         comp_d  = exp_comp;
         ill_d   = exp_illegal;
         valid_d = 1'b1;
      end
      if (sel_for_branch) valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= NOP_INST;
         comp_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so each register samples pre-edge values whatever the statement order.
         valid_q <= valid_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         comp_q  <= comp_d;
         ill_q   <= ill_d;
      end
   end

   assign out_valid       = valid_q;
   assign pc_out          = pc_q;
   assign inst_out        = inst_q;
   assign is_compressed_o = comp_q;
   assign illegal_o       = ill_q;

endmodule
